// File: rtl/fpu_fmovecr_sequencer_pkg.sv
// Shared FPU definitions: extended-format field layout, rounding encodings,
// FPSR condition-code positions and the FMOVECR sequencer states.
package fpu_fmovecr_sequencer_pkg;

  localparam int SIGN_BIT = 79;
  localparam int EXP_MSB  = 78;
  localparam int EXP_LSB  = 64;
  localparam int MANT_MSB = 63;
  localparam int MANT_LSB = 0;

  localparam logic [14:0] EXP_MAX  = 15'h7FFF;
  localparam logic [14:0] EXP_ZERO = 15'h0000;

  typedef enum logic [1:0] {
    PREC_EXT     = 2'b00,
    PREC_SGL     = 2'b01,
    PREC_DBL     = 2'b10,
    PREC_EXT_ALT = 2'b11
  } rnd_prec_t;

  typedef enum logic [1:0] {
    RND_RN = 2'b00,
    RND_RZ = 2'b01,
    RND_RM = 2'b10,
    RND_RP = 2'b11
  } rnd_mode_t;

  localparam int CC_N   = 3;
  localparam int CC_Z   = 2;
  localparam int CC_I   = 1;
  localparam int CC_NAN = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Condition codes of an extended value; the explicit integer bit is ignored for I/NaN.
  function automatic logic [3:0] ext_cond_codes(input logic [79:0] v);
    logic [3:0]  cc;
    logic [14:0] e;
    cc = 4'b0000;
    e  = v[EXP_MSB:EXP_LSB];
    cc[CC_N]   = v[SIGN_BIT];
    cc[CC_Z]   = (e == EXP_ZERO) && (v[MANT_MSB:MANT_LSB] == 64'd0);
    cc[CC_I]   = (e == EXP_MAX) && (v[62:0] == 63'd0);
    cc[CC_NAN] = (e == EXP_MAX) && (v[62:0] != 63'd0);
    return cc;
  endfunction

endpackage

// File: rtl/fpu_ext_rounder.sv
// Combinational round of an 80-bit extended value to extended/single/double
// mantissa width under the four FPCR rounding modes.
module fpu_ext_rounder
  import fpu_fmovecr_sequencer_pkg::*;
(
  input  logic        sign,
  input  logic [14:0] exp,
  input  logic [63:0] mant,
  input  logic [1:0]  prec,
  input  logic [1:0]  mode,
  output logic [79:0] rounded,
  output logic        inexact
);

  logic [63:0] keep_mask_s;
  logic [63:0] unit_s;
  logic        guard_s;
  logic        sticky_s;
  logic        lsb_s;
  logic        inc_s;
  logic        narrow_s;
  logic [64:0] sum_s;

  // Select kept width, guard/sticky and the LSB weight for the target precision.
  always_comb begin
    keep_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
    unit_s      = 64'd0;
    guard_s     = 1'b0;
    sticky_s    = 1'b0;
    lsb_s       = 1'b0;
    narrow_s    = 1'b0;
    case (prec)
      PREC_SGL: begin
        keep_mask_s = 64'hFFFF_FF00_0000_0000;
        unit_s      = 64'h0000_0100_0000_0000;
        guard_s     = mant[39];
        sticky_s    = |mant[38:0];
        lsb_s       = mant[40];
        narrow_s    = 1'b1;
      end
      PREC_DBL: begin
        keep_mask_s = 64'hFFFF_FFFF_FFFF_F800;
        unit_s      = 64'h0000_0000_0000_0800;
        guard_s     = mant[10];
        sticky_s    = |mant[9:0];
        lsb_s       = mant[11];
        narrow_s    = 1'b1;
      end
      default: begin
        keep_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        unit_s      = 64'd0;
        narrow_s    = 1'b0;
      end
    endcase
  end

  // Round-up decision per mode.
  always_comb begin
    inc_s = 1'b0;
    case (mode)
      RND_RN:  inc_s = guard_s & (sticky_s | lsb_s);
      RND_RZ:  inc_s = 1'b0;
      RND_RM:  inc_s = sign & (guard_s | sticky_s);
      RND_RP:  inc_s = ~sign & (guard_s | sticky_s);
      default: inc_s = 1'b0;
    endcase
  end

  assign sum_s = {1'b0, mant & keep_mask_s} + {1'b0, (inc_s ? unit_s : 64'd0)};

  // Assemble the result; zeros, specials and extended precision pass through untouched.
  always_comb begin
    rounded = {sign, exp, mant};
    inexact = 1'b0;
    if (!narrow_s || (exp == EXP_MAX) || ((exp == EXP_ZERO) && (mant == 64'd0))) begin
      rounded = {sign, exp, mant};
      inexact = 1'b0;
    end else if (sum_s[64]) begin
      inexact = 1'b1;
      if (exp == 15'h7FFE) begin
        rounded = {sign, EXP_MAX, 64'd0};
      end else begin
        rounded = {sign, exp + 15'd1, 64'h8000_0000_0000_0000};
      end
    end else begin
      rounded = {sign, exp, sum_s[63:0]};
      inexact = guard_s | sticky_s;
    end
  end

endmodule

// File: rtl/fpu_fmovecr_sequencer_checker.sv
// Protocol assertions for the FMOVECR sequencer / constant ROM handshake.
module fpu_fmovecr_sequencer_checker
  import fpu_fmovecr_sequencer_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input logic   clk,
  input logic   nReset,
  input state_t state,
  input logic   read_enable,
  input logic   constant_valid,
  input logic   done
);

  logic [7:0] since_read_r;

  // Cycles elapsed since the last ROM read strobe, saturating.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      since_read_r <= 8'd0;
    end else if (read_enable) begin
      since_read_r <= 8'd1;
    end else if (since_read_r != 8'hFF && since_read_r != 8'd0) begin
      since_read_r <= since_read_r + 8'd1;
    end
  end

  a_valid_in_wait : assert property (@(posedge clk) disable iff (!nReset)
    constant_valid |-> (state == ST_WAIT) && (int'(since_read_r) >= ROM_LATENCY));

  a_read_one_cycle : assert property (@(posedge clk) disable iff (!nReset)
    read_enable |=> !read_enable);

  a_done_pulse : assert property (@(posedge clk) disable iff (!nReset)
    done |=> !done);

endmodule

// File: rtl/fpu_fmovecr_sequencer.sv
// FMOVECR sequencer: reads an extended constant from the FPU ROM, rounds it to
// the FPCR precision/mode and hands it to the FP register file with a done pulse.
module fpu_fmovecr_sequencer
  import fpu_fmovecr_sequencer_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        start,
  input  logic [6:0]  cr_offset,
  input  logic [2:0]  dest_reg,
  input  logic [1:0]  rnd_prec,
  input  logic [1:0]  rnd_mode,
  output logic [6:0]  rom_offset,
  output logic        read_enable,
  input  logic [79:0] constant_in,
  input  logic        constant_valid,
  output logic        busy,
  output logic        done,
  output logic [79:0] result,
  output logic [2:0]  result_reg,
  output logic [3:0]  fpsr_cc,
  output logic        inexact
);

  state_t      state_r;
  state_t      state_s;

  logic [2:0]  dest_lat_r;
  logic [1:0]  prec_lat_r;
  logic [1:0]  mode_lat_r;
  logic [79:0] const_r;

  logic [6:0]  rom_offset_r;
  logic        read_enable_r;
  logic        busy_r;
  logic        done_r;
  logic [79:0] result_r;
  logic [2:0]  result_reg_r;
  logic [3:0]  fpsr_cc_r;
  logic        inexact_r;

  logic [79:0] rounded_s;
  logic        rnd_inexact_s;

  fpu_ext_rounder u_rounder (
    .sign    (const_r[SIGN_BIT]),
    .exp     (const_r[EXP_MSB:EXP_LSB]),
    .mant    (const_r[MANT_MSB:MANT_LSB]),
    .prec    (prec_lat_r),
    .mode    (mode_lat_r),
    .rounded (rounded_s),
    .inexact (rnd_inexact_s)
  );

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: state_s = ST_WAIT;
      ST_WAIT: begin
        if (constant_valid) begin
          state_s = ST_ROUND;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ROUND: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latches, ROM capture and registered outputs aligned with the next state.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      dest_lat_r    <= 3'd0;
      prec_lat_r    <= 2'd0;
      mode_lat_r    <= 2'd0;
      const_r       <= 80'd0;
      rom_offset_r  <= 7'd0;
      read_enable_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      result_r      <= 80'd0;
      result_reg_r  <= 3'd0;
      fpsr_cc_r     <= 4'd0;
      inexact_r     <= 1'b0;
    end else begin
      read_enable_r <= (state_s == ST_READ);
      busy_r        <= (state_s != ST_IDLE);
      done_r        <= (state_s == ST_DONE);
      if (state_r == ST_IDLE && start) begin
        rom_offset_r <= cr_offset;
        dest_lat_r   <= dest_reg;
        prec_lat_r   <= rnd_prec;
        mode_lat_r   <= rnd_mode;
      end
      if (state_r == ST_WAIT && constant_valid) begin
        const_r <= constant_in;
      end
      if (state_r == ST_ROUND) begin
        result_r     <= rounded_s;
        result_reg_r <= dest_lat_r;
        fpsr_cc_r    <= ext_cond_codes(rounded_s);
        inexact_r    <= rnd_inexact_s;
      end
    end
  end

  assign rom_offset  = rom_offset_r;
  assign read_enable = read_enable_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign result_reg  = result_reg_r;
  assign fpsr_cc     = fpsr_cc_r;
  assign inexact     = inexact_r;

  fpu_fmovecr_sequencer_checker #(.ROM_LATENCY(ROM_LATENCY)) u_checker (
    .clk            (clk),
    .nReset         (nReset),
    .state          (state_r),
    .read_enable    (read_enable_r),
    .constant_valid (constant_valid),
    .done           (done_r)
  );

endmodule

// File: tb/tb_fpu_fmovecr_sequencer.sv
// Scoreboard bench for fpu_fmovecr_sequencer with a behavioural constant ROM.
module tb_fpu_fmovecr_sequencer;

  logic        clk = 1'b0;
  logic        nReset;
  logic        start;
  logic [6:0]  cr_offset;
  logic [2:0]  dest_reg;
  logic [1:0]  rnd_prec;
  logic [1:0]  rnd_mode;
  logic [6:0]  rom_offset;
  logic        read_enable;
  logic [79:0] constant_in;
  logic        constant_valid;
  logic        busy;
  logic        done;
  logic [79:0] result;
  logic [2:0]  result_reg;
  logic [3:0]  fpsr_cc;
  logic        inexact;

  localparam logic [79:0] PI_EXT  = 80'h4000_C90FDAA22168C235;
  localparam logic [79:0] LN2_EXT = 80'h3FFE_B17217F7D1CF79AC;
  localparam logic [79:0] JUNK    = 80'hDEAD_BEEF_0123_4567_89AB;

  always #5 clk = ~clk;

  fpu_fmovecr_sequencer #(.ROM_LATENCY(1)) dut (
    .clk            (clk),
    .nReset         (nReset),
    .start          (start),
    .cr_offset      (cr_offset),
    .dest_reg       (dest_reg),
    .rnd_prec       (rnd_prec),
    .rnd_mode       (rnd_mode),
    .rom_offset     (rom_offset),
    .read_enable    (read_enable),
    .constant_in    (constant_in),
    .constant_valid (constant_valid),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .result_reg     (result_reg),
    .fpsr_cc        (fpsr_cc),
    .inexact        (inexact)
  );

  int          rom_delay = 0;
  bit          inject_en = 1'b0;
  logic [79:0] inject_val = 80'd0;
  logic [79:0] rom_data;
  bit          rom_pend;
  int          rom_cnt;

  function automatic logic [79:0] rom_lookup(input logic [6:0] o);
    logic [79:0] v;
    case (o)
      7'h00:   v = PI_EXT;
      7'h30:   v = LN2_EXT;
      7'h0F:   v = 80'd0;
      default: v = 80'd0;
    endcase
    if (inject_en) v = inject_val;
    return v;
  endfunction

  // ROM model: one-cycle latency plus rom_delay extra cycles, junk on the bus while not valid.
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      constant_valid <= 1'b0;
      constant_in    <= 80'd0;
      rom_data       <= 80'd0;
      rom_pend       <= 1'b0;
      rom_cnt        <= 0;
    end else if (read_enable) begin
      rom_data <= rom_lookup(rom_offset);
      if (rom_delay == 0) begin
        constant_valid <= 1'b1;
        constant_in    <= rom_lookup(rom_offset);
        rom_pend       <= 1'b0;
      end else begin
        constant_valid <= 1'b0;
        constant_in    <= JUNK;
        rom_pend       <= 1'b1;
        rom_cnt        <= rom_delay;
      end
    end else if (rom_pend) begin
      if (rom_cnt == 1) begin
        constant_valid <= 1'b1;
        constant_in    <= rom_data;
        rom_pend       <= 1'b0;
      end else begin
        rom_cnt        <= rom_cnt - 1;
        constant_valid <= 1'b0;
        constant_in    <= JUNK;
      end
    end else begin
      constant_valid <= 1'b0;
      constant_in    <= JUNK;
    end
  end

  typedef struct {
    logic [79:0] res;
    logic [2:0]  rreg;
    logic [3:0]  cc;
    logic        inex;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_done   = 0;
  int   n_accept = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected response.
  always @(negedge clk) begin
    if (nReset === 1'b1 && done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_done: done seen with empty scoreboard at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("result_reg", 80'(result_reg), 80'(e.rreg));
        check("fpsr_cc", 80'(fpsr_cc), 80'(e.cc));
        check("inexact", 80'(inexact), 80'(e.inex));
        check("done_cycle", 80'(cyc), 80'(e.cyc));
      end
    end
  end

  // Drive one request; start accepted at edge T, done expected before edge T+4 (+ROM delay).
  task automatic issue(input logic [6:0] off, input logic [2:0] dr, input logic [1:0] p,
                       input logic [1:0] m, input int dly, input logic [79:0] er,
                       input logic [3:0] ecc, input logic ei, input bit expect_done);
    rom_delay = dly;
    @(negedge clk);
    start = 1'b1; cr_offset = off; dest_reg = dr; rnd_prec = p; rnd_mode = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_accept++;
    if (expect_done) sb.push_back('{er, dr, ecc, ei, cyc + 3 + dly});
  endtask

  task automatic run(input logic [6:0] off, input logic [2:0] dr, input logic [1:0] p,
                     input logic [1:0] m, input int dly, input logic [79:0] er,
                     input logic [3:0] ecc, input logic ei);
    issue(off, dr, p, m, dly, er, ecc, ei, 1'b1);
    repeat (6 + dly) @(negedge clk);
    check("busy_idle", 80'(busy), 80'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; start = 1'b0; cr_offset = 7'd0; dest_reg = 3'd0;
    rnd_prec = 2'b00; rnd_mode = 2'b00;
    #12;
    check("rst_result", result, 80'd0);
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_done", 80'(done), 80'd0);
    check("rst_read_enable", 80'(read_enable), 80'd0);
    check("rst_cc", 80'(fpsr_cc), 80'd0);
    @(negedge clk);
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    run(7'h00, 3'd3, 2'b00, 2'b00, 0, PI_EXT, 4'b0000, 1'b0);
    run(7'h00, 3'd1, 2'b01, 2'b00, 0, 80'h4000_C90FDB0000000000, 4'b0000, 1'b1);
    run(7'h00, 3'd2, 2'b01, 2'b01, 0, 80'h4000_C90FDA0000000000, 4'b0000, 1'b1);
    run(7'h30, 3'd4, 2'b10, 2'b00, 2, 80'h3FFE_B17217F7D1CF7800, 4'b0000, 1'b1);
    run(7'h30, 3'd6, 2'b10, 2'b11, 0, 80'h3FFE_B17217F7D1CF8000, 4'b0000, 1'b1);
    run(7'h0F, 3'd7, 2'b01, 2'b11, 0, 80'd0, 4'b0100, 1'b0);
    run(7'h05, 3'd0, 2'b01, 2'b11, 1, 80'd0, 4'b0100, 1'b0);
    run(7'h30, 3'd5, 2'b11, 2'b10, 0, LN2_EXT, 4'b0000, 1'b0);

    inject_en = 1'b1;
    inject_val = 80'h3FFF_FFFFFFFFFFFFFFFF;
    run(7'h7F, 3'd5, 2'b01, 2'b00, 0, 80'h4000_8000000000000000, 4'b0000, 1'b1);
    inject_val = 80'h7FFE_FFFFFFFFFFFFFFFF;
    run(7'h7F, 3'd2, 2'b01, 2'b00, 0, 80'h7FFF_0000000000000000, 4'b0010, 1'b1);
    inject_val = 80'hC000_C90FDAA22168C235;
    run(7'h7F, 3'd1, 2'b01, 2'b10, 0, 80'hC000_C90FDB0000000000, 4'b1000, 1'b1);
    run(7'h7F, 3'd6, 2'b01, 2'b11, 0, 80'hC000_C90FDA0000000000, 4'b1000, 1'b1);
    inject_en = 1'b0;

    // Extra start pulses during READ and WAIT must not spawn a second request.
    issue(7'h00, 3'd5, 2'b00, 2'b00, 2, PI_EXT, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; cr_offset = 7'h30; dest_reg = 3'd1; rnd_prec = 2'b10;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("ignored_start_done_count", 80'(n_done), 80'(n_accept));

    // Reset while waiting on the ROM: outputs clear at once and no done follows.
    issue(7'h30, 3'd6, 2'b10, 2'b00, 4, 80'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    nReset = 1'b0;
    #1;
    check("arst_result", result, 80'd0);
    check("arst_rom_offset", 80'(rom_offset), 80'd0);
    check("arst_busy", 80'(busy), 80'd0);
    check("arst_done", 80'(done), 80'd0);
    check("arst_read_enable", 80'(read_enable), 80'd0);
    check("arst_result_reg", 80'(result_reg), 80'd0);
    check("arst_cc", 80'(fpsr_cc), 80'd0);
    check("arst_inexact", 80'(inexact), 80'd0);
    @(negedge clk);
    nReset = 1'b1;
    repeat (8) @(negedge clk);
    n_accept--;
    check("arst_no_done", 80'(n_done), 80'(n_accept));
    run(7'h30, 3'd4, 2'b10, 2'b00, 0, 80'h3FFE_B17217F7D1CF7800, 4'b0000, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 80'(sb.size()), 80'd0);
    check("done_count", 80'(n_done), 80'(n_accept));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
